// File: rtl/approx_product_error_accumulator.sv
// Error characterisation of an approximate multiplier: compares each accepted product
// against the exact product and accumulates error count, error-distance sum and maximum.
module approx_product_error_accumulator #(
    parameter int WIDTH   = 4,
    parameter int SAMPLES = 256,
    parameter int ACC_W   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in1,
    input  logic [WIDTH-1:0]     in2,
    input  logic [2*WIDTH-1:0]   prod,
    output logic                 busy,
    output logic                 done,
    output logic [15:0]          err_count,
    output logic [ACC_W-1:0]     ed_sum,
    output logic [2*WIDTH-1:0]   ed_max
);

    localparam int PW = 2 * WIDTH;
    localparam logic [15:0] LAST_IDX = 16'(SAMPLES - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t             state_reg;
    logic               in_ready_reg;
    logic               busy_reg;
    logic               done_reg;
    logic [15:0]        count_reg;

    logic               s1_valid_reg;
    logic [WIDTH-1:0]   s1_in1_reg;
    logic [WIDTH-1:0]   s1_in2_reg;
    logic [PW-1:0]      s1_prod_reg;

    logic [15:0]        err_count_reg;
    logic [ACC_W-1:0]   ed_sum_reg;
    logic [PW-1:0]      ed_max_reg;

    logic               accept;
    logic [PW-1:0]      exact_next;
    logic [PW-1:0]      ed_next;
    logic [ACC_W:0]     sum_wide_next;
    logic [ACC_W-1:0]   sum_sat_next;

    // in_ready is a register that is high exactly in RUN, so acceptance never feeds back from in_valid
    assign accept = in_valid & in_ready_reg;

    always_comb begin
        exact_next    = {{WIDTH{1'b0}}, s1_in1_reg} * {{WIDTH{1'b0}}, s1_in2_reg};
        ed_next       = (exact_next >= s1_prod_reg) ? (exact_next - s1_prod_reg)
                                                    : (s1_prod_reg - exact_next);
        sum_wide_next = {1'b0, ed_sum_reg} + {{(ACC_W + 1 - PW){1'b0}}, ed_next};
        sum_sat_next  = sum_wide_next[ACC_W] ? {ACC_W{1'b1}} : sum_wide_next[ACC_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            in_ready_reg  <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            count_reg     <= '0;
            s1_valid_reg  <= 1'b0;
            s1_in1_reg    <= '0;
            s1_in2_reg    <= '0;
            s1_prod_reg   <= '0;
            err_count_reg <= '0;
            ed_sum_reg    <= '0;
            ed_max_reg    <= '0;
        end else begin
            s1_valid_reg <= accept;
            if (accept) begin
                s1_in1_reg  <= in1;
                s1_in2_reg  <= in2;
                s1_prod_reg <= prod;
            end

            if (s1_valid_reg) begin
                err_count_reg <= err_count_reg + {15'd0, (ed_next != '0)};
                ed_sum_reg    <= sum_sat_next;
                if (ed_next > ed_max_reg) begin
                    ed_max_reg <= ed_next;
                end
            end

            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        state_reg     <= RUN;
                        in_ready_reg  <= 1'b1;
                        busy_reg      <= 1'b1;
                        count_reg     <= '0;
                        err_count_reg <= '0;
                        ed_sum_reg    <= '0;
                        ed_max_reg    <= '0;
                    end
                end
                RUN: begin
                    if (accept) begin
                        if (count_reg == LAST_IDX) begin
                            state_reg    <= DRAIN;
                            in_ready_reg <= 1'b0;
                        end else begin
                            count_reg <= count_reg + 16'd1;
                        end
                    end
                end
                DRAIN: begin
                    state_reg <= DONE;
                    done_reg  <= 1'b1;
                end
                DONE: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
                default: begin
                    state_reg    <= IDLE;
                    in_ready_reg <= 1'b0;
                    busy_reg     <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_reg;
    assign busy      = busy_reg;
    assign done      = done_reg;
    assign err_count = err_count_reg;
    assign ed_sum    = ed_sum_reg;
    assign ed_max    = ed_max_reg;

endmodule
